// File: rtl/prio_arbiter_ctrl.sv
// Fixed-priority arbiter for four requesters (req[4] highest) with per-grant hold cap,
// a one-cycle gap between owners and one-shot masking of a timed-out owner.
module prio_arbiter_ctrl #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:1] req,
    output logic [4:1] gnt,
    output logic [2:0] gnt_code,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01,
        StGap   = 2'b10
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [4:1]         mask_q;
    logic [2:0]         owner_q;

    logic [4:1]         eff;
    logic [4:1]         win_gnt;
    logic [2:0]         win_code;
    logic               owner_req;

    // Mask only steers the choice; a sole masked requester still wins.
    always_comb begin
        eff = req & ~mask_q;
        if (eff == 4'b0000) begin
            eff = req;
        end
        win_gnt  = 4'b0000;
        win_code = 3'd0;
        if (eff[4]) begin
            win_gnt  = 4'b1000;
            win_code = 3'd4;
        end else if (eff[3]) begin
            win_gnt  = 4'b0100;
            win_code = 3'd3;
        end else if (eff[2]) begin
            win_gnt  = 4'b0010;
            win_code = 3'd2;
        end else if (eff[1]) begin
            win_gnt  = 4'b0001;
            win_code = 3'd1;
        end
    end

    assign owner_req = |(req & gnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mask_q   <= 4'b0000;
            owner_q  <= 3'd0;
            gnt      <= 4'b0000;
            gnt_code <= 3'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    timeout <= 1'b0;
                    if (win_code != 3'd0) begin
                        state_q  <= StGrant;
                        gnt      <= win_gnt;
                        gnt_code <= win_code;
                        busy     <= 1'b1;
                        cnt_q    <= CNT_W'(1);
                        owner_q  <= win_code;
                        mask_q   <= 4'b0000;
                    end else begin
                        gnt      <= 4'b0000;
                        gnt_code <= 3'd0;
                        busy     <= 1'b0;
                    end
                end
                StGrant: begin
                    if (!owner_req) begin
                        state_q  <= StGap;
                        gnt      <= 4'b0000;
                        gnt_code <= 3'd0;
                        busy     <= 1'b0;
                        timeout  <= 1'b0;
                    end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
                        state_q  <= StGap;
                        gnt      <= 4'b0000;
                        gnt_code <= 3'd0;
                        busy     <= 1'b0;
                        timeout  <= 1'b1;
                        mask_q   <= mask_q | gnt;
                    end else begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                    end
                end
                StGap: begin
                    state_q  <= StIdle;
                    gnt      <= 4'b0000;
                    gnt_code <= 3'd0;
                    busy     <= 1'b0;
                    timeout  <= 1'b0;
                end
                default: begin
                    state_q  <= StIdle;
                    cnt_q    <= '0;
                    mask_q   <= 4'b0000;
                    owner_q  <= 3'd0;
                    gnt      <= 4'b0000;
                    gnt_code <= 3'd0;
                    busy     <= 1'b0;
                    timeout  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_arbiter_ctrl.sv
// Directed bench for prio_arbiter_ctrl: fixed vectors with hand-derived expected outputs.
module tb_prio_arbiter_ctrl;

    logic       clk;
    logic       reset;
    logic [4:1] req;
    logic [4:1] gnt;
    logic [2:0] gnt_code;
    logic       busy;
    logic       timeout;

    int checks;
    int errors;

    prio_arbiter_ctrl #(
        .MAX_HOLD(8),
        .CNT_W   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_code(gnt_code),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:1] eg, input logic [2:0] ec,
                         input logic eb, input logic et);
        checks++;
        assert ({gnt, gnt_code, busy, timeout} === {eg, ec, eb, et}) else begin
            errors++;
            $error("FAIL %s: got gnt=%b code=%0d busy=%b timeout=%b, want gnt=%b code=%0d busy=%b timeout=%b",
                   tag, gnt, gnt_code, busy, timeout, eg, ec, eb, et);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        tick();
        tick();
        check("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // 1) idle with no requests
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle", 4'b0000, 3'd0, 1'b0, 1'b0);
        end

        // 2) req3 beats req2, released after 3 grant cycles
        req = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_grant3", 4'b0100, 3'd3, 1'b1, 1'b0);
        end
        req = 4'b0010;
        tick();
        check("t2_gap", 4'b0000, 3'd0, 1'b0, 1'b0);
        tick();
        check("t2_idle", 4'b0000, 3'd0, 1'b0, 1'b0);
        tick();
        check("t2_grant2", 4'b0010, 3'd2, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        tick();
        tick();
        check("t2_back_idle", 4'b0000, 3'd0, 1'b0, 1'b0);

        // 3) req4 held past MAX_HOLD, then masked in favour of req1
        req = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t3_hold4", 4'b1000, 3'd4, 1'b1, 1'b0);
        end
        tick();
        check("t3_timeout", 4'b0000, 3'd0, 1'b0, 1'b1);
        tick();
        check("t3_idle", 4'b0000, 3'd0, 1'b0, 1'b0);
        tick();
        check("t3_masked_grant1", 4'b0001, 3'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        tick();
        tick();
        check("t3_back_idle", 4'b0000, 3'd0, 1'b0, 1'b0);

        // 4) sole requester times out and is re-granted despite the mask
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t4_hold3", 4'b0100, 3'd3, 1'b1, 1'b0);
        end
        tick();
        check("t4_timeout", 4'b0000, 3'd0, 1'b0, 1'b1);
        tick();
        check("t4_idle", 4'b0000, 3'd0, 1'b0, 1'b0);
        tick();
        check("t4_regrant3", 4'b0100, 3'd3, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        tick();
        tick();
        check("t4_back_idle", 4'b0000, 3'd0, 1'b0, 1'b0);

        // 5) higher priority arrival does not preempt
        req = 4'b0001;
        tick();
        check("t5_grant1", 4'b0001, 3'd1, 1'b1, 1'b0);
        req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_preempt", 4'b0001, 3'd1, 1'b1, 1'b0);
        end
        req = 4'b1000;
        tick();
        check("t5_gap", 4'b0000, 3'd0, 1'b0, 1'b0);
        tick();
        check("t5_idle", 4'b0000, 3'd0, 1'b0, 1'b0);
        tick();
        check("t5_grant4", 4'b1000, 3'd4, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        tick();
        tick();
        check("t5_back_idle", 4'b0000, 3'd0, 1'b0, 1'b0);

        // 6) reset in mid-grant, then a fresh grant runs a full MAX_HOLD
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_pre_reset", 4'b0100, 3'd3, 1'b1, 1'b0);
        end
        reset = 1'b1;
        tick();
        check("t6_reset", 4'b0000, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        req   = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_hold2", 4'b0010, 3'd2, 1'b1, 1'b0);
        end
        tick();
        check("t6_timeout", 4'b0000, 3'd0, 1'b0, 1'b1);
        req = 4'b0000;
        tick();
        check("t6_idle", 4'b0000, 3'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
